// File: rtl/uart_dbg_pkg.sv
// Shared constants and FSM state type for the UART debug register bridge.
// Contents:
//   CMD_WR / CMD_RD   host command bytes ('W' / 'R')
//   RSP_OK / RSP_ERR  response bytes ('K' / 'E')
//   dbg_state_t       bridge FSM states
package uart_dbg_pkg;

   localparam logic [7:0] CMD_WR  = 8'h57;
   localparam logic [7:0] CMD_RD  = 8'h52;
   localparam logic [7:0] RSP_OK  = 8'h4B;
   localparam logic [7:0] RSP_ERR = 8'h45;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADDR = 3'd1,
      ST_DATA = 3'd2,
      ST_BUS  = 3'd3,
      ST_RESP = 3'd4
   } dbg_state_t;

endpackage

// File: rtl/uart_dbg_ser.sv
// Response serializer: loads a DATA_BYTES-wide word and a byte count, then
// emits the top `len` bytes MSB first over a txv/cts handshake.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   load       one-cycle strobe: capture word/len and start sending
//   word       response word, first byte in the most significant byte
//   len        number of bytes to send (1..DATA_BYTES)
//   cts        transmitter ready
//   txd        byte being offered
//   txv        transfer strobe, only ever high together with cts
//   done       high in the cycle the last byte transfers
module uart_dbg_ser #(
   parameter int unsigned DATA_BYTES = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              load,
   input  logic [8*DATA_BYTES-1:0]           word,
   input  logic [$clog2(DATA_BYTES+1)-1:0]   len,
   input  logic                              cts,
   output logic [7:0]                        txd,
   output logic                              txv,
   output logic                              done
);

   localparam int unsigned DW = 8 * DATA_BYTES;
   localparam int unsigned LW = $clog2(DATA_BYTES + 1);

   logic [DW-1:0] sreg;
   logic [LW-1:0] rem;
   logic          vld;
   logic          gap;
   logic          take;

   // A byte moves only in a cycle where cts is high; vld drops right after
   // so the following cycle ignores cts, giving a 2-cycle minimum spacing.
   assign take = vld & cts;
   assign txv  = take;
   assign done = take & (rem == LW'(1));

   // Byte shifter and handshake state.
   always_ff @(posedge clk) begin
      if (rst) begin
         txd  <= 8'h00;
         sreg <= '0;
         rem  <= '0;
         vld  <= 1'b0;
         gap  <= 1'b0;
      end else if (load) begin
         txd  <= word[DW-1 -: 8];
         sreg <= word << 8;
         rem  <= len;
         vld  <= (len != '0);
         gap  <= 1'b0;
      end else if (take) begin
         vld <= 1'b0;
         rem <= rem - LW'(1);
         if (rem != LW'(1)) begin
            txd  <= sreg[DW-1 -: 8];
            sreg <= sreg << 8;
            gap  <= 1'b1;
         end
      end else if (gap) begin
         gap <= 1'b0;
         vld <= 1'b1;
      end
   end

endmodule

// File: rtl/uart_dbg_bridge.sv
// UART debug bridge: parses 'W'/'R' host frames from the received byte
// stream, performs one request/acknowledge bus access per frame and returns
// 'K', the read data, or 'E' through the transmit byte interface.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rxd, rxv            received byte and its one-cycle strobe
//   txd, txv, cts       transmit byte, transfer strobe, transmitter ready
//   bus_req, bus_we     access request (held until ack/timeout), write enable
//   bus_addr, bus_wdat  word address and write data, stable during bus_req
//   bus_rdat, bus_ack   read data and one-cycle completion strobe
module uart_dbg_bridge
   import uart_dbg_pkg::*;
#(
   parameter int unsigned ADDR_BYTES  = 2,
   parameter int unsigned DATA_BYTES  = 4,
   parameter int unsigned RX_TIMEOUT  = 1250000,
   parameter int unsigned BUS_TIMEOUT = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [7:0]                rxd,
   input  logic                      rxv,
   output logic [7:0]                txd,
   output logic                      txv,
   input  logic                      cts,
   output logic                      bus_req,
   output logic                      bus_we,
   output logic [8*ADDR_BYTES-1:0]   bus_addr,
   output logic [8*DATA_BYTES-1:0]   bus_wdat,
   input  logic [8*DATA_BYTES-1:0]   bus_rdat,
   input  logic                      bus_ack
);

   localparam int unsigned AW   = 8 * ADDR_BYTES;
   localparam int unsigned DW   = 8 * DATA_BYTES;
   localparam int unsigned MAXB = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
   localparam int unsigned CW   = $clog2(MAXB + 1);
   localparam int unsigned LW   = $clog2(DATA_BYTES + 1);
   localparam int unsigned RW   = $clog2(RX_TIMEOUT + 1);
   localparam int unsigned BW   = $clog2(BUS_TIMEOUT + 1);

   dbg_state_t    state;
   logic [CW-1:0] cnt;
   logic [RW-1:0] rx_tmr;
   logic [BW-1:0] bus_tmr;
   logic          ld;
   logic [DW-1:0] ld_word;
   logic [LW-1:0] ld_len;
   logic          ser_done;

   // Single-byte responses travel in the top byte of the serializer word.
   function automatic logic [DW-1:0] rsp_word(input logic [7:0] b);
      rsp_word = DW'(b) << (DW - 8);
   endfunction

   // Frame parser, bus sequencer and response launcher.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         rx_tmr   <= '0;
         bus_tmr  <= '0;
         bus_req  <= 1'b0;
         bus_we   <= 1'b0;
         bus_addr <= '0;
         bus_wdat <= '0;
         ld       <= 1'b0;
         ld_word  <= '0;
         ld_len   <= '0;
      end else begin
         ld <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (rxv) begin
                  cnt    <= '0;
                  rx_tmr <= '0;
                  if (rxd == CMD_WR || rxd == CMD_RD) begin
                     bus_we <= (rxd == CMD_WR);
                     state  <= ST_ADDR;
                  end else begin
                     ld      <= 1'b1;
                     ld_word <= rsp_word(RSP_ERR);
                     ld_len  <= LW'(1);
                     state   <= ST_RESP;
                  end
               end
            end

            // A byte arriving in the expiry cycle wins over the timeout.
            ST_ADDR: begin
               if (rxv) begin
                  bus_addr <= AW'({bus_addr, rxd});
                  rx_tmr   <= '0;
                  if (cnt == CW'(ADDR_BYTES - 1)) begin
                     cnt <= '0;
                     if (bus_we) begin
                        state <= ST_DATA;
                     end else begin
                        state   <= ST_BUS;
                        bus_req <= 1'b1;
                        bus_tmr <= BW'(1);
                     end
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end else if (rx_tmr == RW'(RX_TIMEOUT)) begin
                  cnt   <= '0;
                  state <= ST_IDLE;
               end else begin
                  rx_tmr <= rx_tmr + RW'(1);
               end
            end

            ST_DATA: begin
               if (rxv) begin
                  bus_wdat <= DW'({bus_wdat, rxd});
                  rx_tmr   <= '0;
                  if (cnt == CW'(DATA_BYTES - 1)) begin
                     cnt     <= '0;
                     state   <= ST_BUS;
                     bus_req <= 1'b1;
                     bus_tmr <= BW'(1);
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end else if (rx_tmr == RW'(RX_TIMEOUT)) begin
                  cnt   <= '0;
                  state <= ST_IDLE;
               end else begin
                  rx_tmr <= rx_tmr + RW'(1);
               end
            end

            // bus_tmr counts request cycles from 1; ack on the last one succeeds.
            ST_BUS: begin
               if (bus_ack) begin
                  bus_req <= 1'b0;
                  ld      <= 1'b1;
                  state   <= ST_RESP;
                  if (bus_we) begin
                     ld_word <= rsp_word(RSP_OK);
                     ld_len  <= LW'(1);
                  end else begin
                     ld_word <= bus_rdat;
                     ld_len  <= LW'(DATA_BYTES);
                  end
               end else if (bus_tmr == BW'(BUS_TIMEOUT)) begin
                  bus_req <= 1'b0;
                  ld      <= 1'b1;
                  ld_word <= rsp_word(RSP_ERR);
                  ld_len  <= LW'(1);
                  state   <= ST_RESP;
               end else begin
                  bus_tmr <= bus_tmr + BW'(1);
               end
            end

            ST_RESP: begin
               if (ser_done) begin
                  state <= ST_IDLE;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

   uart_dbg_ser #(
      .DATA_BYTES (DATA_BYTES)
   ) u_ser (
      .clk  (clk),
      .rst  (rst),
      .load (ld),
      .word (ld_word),
      .len  (ld_len),
      .cts  (cts),
      .txd  (txd),
      .txv  (txv),
      .done (ser_done)
   );

endmodule

// File: tb/tb_uart_dbg_bridge.sv
// Directed self-checking bench for uart_dbg_bridge.
module tb_uart_dbg_bridge;

   localparam int unsigned RXT = 40;
   localparam int unsigned BT  = 255;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rxd;
   logic        rxv;
   logic [7:0]  txd;
   logic        txv;
   logic        cts;
   logic        bus_req;
   logic        bus_we;
   logic [15:0] bus_addr;
   logic [31:0] bus_wdat;
   logic [31:0] bus_rdat;
   logic        bus_ack;

   int          pass_cnt = 0;
   int          total_cnt = 0;
   int          breq_cycles = 0;
   logic        prev_txv = 1'b0;
   logic        cts_rand = 1'b0;
   logic [7:0]  txq [$];

   uart_dbg_bridge #(
      .ADDR_BYTES  (2),
      .DATA_BYTES  (4),
      .RX_TIMEOUT  (RXT),
      .BUS_TIMEOUT (BT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rxd      (rxd),
      .rxv      (rxv),
      .txd      (txd),
      .txv      (txv),
      .cts      (cts),
      .bus_req  (bus_req),
      .bus_we   (bus_we),
      .bus_addr (bus_addr),
      .bus_wdat (bus_wdat),
      .bus_rdat (bus_rdat),
      .bus_ack  (bus_ack)
   );

   always #5 clk = ~clk;

   // Transmit-side monitor: captures bytes and checks the cts/spacing rules.
   always @(negedge clk) begin
      if (txv === 1'b1) begin
         total_cnt++;
         if (cts !== 1'b1) $display("FAIL txv_cts: cts=%b with txv, required 1", cts);
         else pass_cnt++;
         total_cnt++;
         if (prev_txv) $display("FAIL txv_spacing: txv in adjacent cycles, required gap");
         else pass_cnt++;
         txq.push_back(txd);
      end
      prev_txv = (txv === 1'b1);
      if (bus_req === 1'b1) breq_cycles++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (cts_rand) cts = 1'($urandom_range(0, 1));
   endtask

   task automatic send_byte(input logic [7:0] b);
      rxd = b;
      rxv = 1'b1;
      tick();
      rxv = 1'b0;
   endtask

   task automatic wait_tx(input int n, input int bound);
      for (int i = 0; i < bound; i++) begin
         if (txq.size() >= n) break;
         tick();
      end
      repeat (3) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      total_cnt++; if (txd !== 8'h00) $display("FAIL rst_txd: got %h required 00", txd); else pass_cnt++;
      total_cnt++; if (txv !== 1'b0) $display("FAIL rst_txv: got %b required 0", txv); else pass_cnt++;
      total_cnt++; if (bus_req !== 1'b0) $display("FAIL rst_req: got %b required 0", bus_req); else pass_cnt++;
      total_cnt++; if (bus_we !== 1'b0) $display("FAIL rst_we: got %b required 0", bus_we); else pass_cnt++;
      total_cnt++; if (bus_addr !== 16'h0000) $display("FAIL rst_addr: got %h required 0000", bus_addr); else pass_cnt++;
      total_cnt++; if (bus_wdat !== 32'h0) $display("FAIL rst_wdat: got %h required 00000000", bus_wdat); else pass_cnt++;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_write();
      logic [7:0] fr [0:6];
      fr = '{8'h57, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      txq.delete();
      for (int i = 0; i < 7; i++) send_byte(fr[i]);
      total_cnt++; if (bus_req !== 1'b1) $display("FAIL wr_req_rise: got %b required 1", bus_req); else pass_cnt++;
      total_cnt++; if (bus_we !== 1'b1) $display("FAIL wr_we: got %b required 1", bus_we); else pass_cnt++;
      total_cnt++; if (bus_addr !== 16'h0010) $display("FAIL wr_addr: got %h required 0010", bus_addr); else pass_cnt++;
      total_cnt++; if (bus_wdat !== 32'hDEADBEEF) $display("FAIL wr_wdat: got %h required deadbeef", bus_wdat); else pass_cnt++;
      repeat (3) tick();
      total_cnt++; if (bus_req !== 1'b1) $display("FAIL wr_req_hold: got %b required 1", bus_req); else pass_cnt++;
      bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0;
      total_cnt++; if (bus_req !== 1'b0) $display("FAIL wr_req_fall: got %b required 0", bus_req); else pass_cnt++;
      wait_tx(1, 50);
      total_cnt++; if (txq.size() != 1) $display("FAIL wr_tx_count: got %0d required 1", txq.size()); else pass_cnt++;
      total_cnt++;
      if (txq.size() < 1 || txq[0] !== 8'h4B) $display("FAIL wr_tx_byte: got %h required 4b", (txq.size() > 0) ? txq[0] : 8'hxx);
      else pass_cnt++;
   endtask

   task automatic test_read();
      logic [7:0] exp [0:3];
      logic [7:0] got;
      exp = '{8'h12, 8'h34, 8'h56, 8'h78};
      txq.delete();
      cts_rand = 1'b1;
      send_byte(8'h52);
      send_byte(8'h00);
      send_byte(8'h20);
      total_cnt++; if (bus_req !== 1'b1) $display("FAIL rd_req_rise: got %b required 1", bus_req); else pass_cnt++;
      total_cnt++; if (bus_we !== 1'b0) $display("FAIL rd_we: got %b required 0", bus_we); else pass_cnt++;
      total_cnt++; if (bus_addr !== 16'h0020) $display("FAIL rd_addr: got %h required 0020", bus_addr); else pass_cnt++;
      bus_rdat = 32'h12345678;
      bus_ack  = 1'b1;
      tick();
      bus_ack  = 1'b0;
      bus_rdat = 32'hFFFFFFFF;
      total_cnt++; if (bus_req !== 1'b0) $display("FAIL rd_req_fall: got %b required 0", bus_req); else pass_cnt++;
      wait_tx(4, 400);
      cts_rand = 1'b0;
      cts = 1'b1;
      total_cnt++; if (txq.size() != 4) $display("FAIL rd_tx_count: got %0d required 4", txq.size()); else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         got = (i < txq.size()) ? txq[i] : 8'hxx;
         total_cnt++;
         if (got !== exp[i]) $display("FAIL rd_tx_byte%0d: got %h required %h", i, got, exp[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_unknown();
      logic [7:0] exp [0:4];
      logic [7:0] got;
      exp = '{8'h45, 8'hA5, 8'hA5, 8'h5A, 8'h5A};
      txq.delete();
      breq_cycles = 0;
      send_byte(8'h41);
      tick();
      total_cnt++; if (txv !== 1'b1) $display("FAIL unk_txv_latency: got %b required 1", txv); else pass_cnt++;
      total_cnt++; if (txd !== 8'h45) $display("FAIL unk_txd: got %h required 45", txd); else pass_cnt++;
      tick();
      total_cnt++; if (breq_cycles != 0) $display("FAIL unk_no_req: got %0d request cycles required 0", breq_cycles); else pass_cnt++;
      // First byte lands in the cycle IDLE is re-entered.
      send_byte(8'h52);
      send_byte(8'h00);
      send_byte(8'h20);
      total_cnt++; if (bus_req !== 1'b1) $display("FAIL unk_next_req: got %b required 1", bus_req); else pass_cnt++;
      total_cnt++; if (bus_addr !== 16'h0020) $display("FAIL unk_next_addr: got %h required 0020", bus_addr); else pass_cnt++;
      bus_rdat = 32'hA5A55A5A;
      bus_ack  = 1'b1;
      tick();
      bus_ack  = 1'b0;
      wait_tx(5, 100);
      total_cnt++; if (txq.size() != 5) $display("FAIL unk_tx_count: got %0d required 5", txq.size()); else pass_cnt++;
      for (int i = 0; i < 5; i++) begin
         got = (i < txq.size()) ? txq[i] : 8'hxx;
         total_cnt++;
         if (got !== exp[i]) $display("FAIL unk_tx_byte%0d: got %h required %h", i, got, exp[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_rx_timeout();
      logic [7:0] exp [0:3];
      logic [7:0] got;
      exp = '{8'h0B, 8'hAD, 8'h00, 8'h04};
      txq.delete();
      breq_cycles = 0;
      send_byte(8'h57);
      send_byte(8'h00);
      repeat (RXT + 1) tick();
      total_cnt++; if (breq_cycles != 0) $display("FAIL to_no_req: got %0d request cycles required 0", breq_cycles); else pass_cnt++;
      total_cnt++; if (txq.size() != 0) $display("FAIL to_no_tx: got %0d bytes required 0", txq.size()); else pass_cnt++;
      send_byte(8'h52);
      send_byte(8'h00);
      send_byte(8'h04);
      total_cnt++; if (bus_req !== 1'b1) $display("FAIL to_next_req: got %b required 1", bus_req); else pass_cnt++;
      total_cnt++; if (bus_we !== 1'b0) $display("FAIL to_next_we: got %b required 0", bus_we); else pass_cnt++;
      total_cnt++; if (bus_addr !== 16'h0004) $display("FAIL to_next_addr: got %h required 0004", bus_addr); else pass_cnt++;
      bus_rdat = 32'h0BAD0004;
      bus_ack  = 1'b1;
      tick();
      bus_ack  = 1'b0;
      wait_tx(4, 100);
      total_cnt++; if (txq.size() != 4) $display("FAIL to_tx_count: got %0d required 4", txq.size()); else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         got = (i < txq.size()) ? txq[i] : 8'hxx;
         total_cnt++;
         if (got !== exp[i]) $display("FAIL to_tx_byte%0d: got %h required %h", i, got, exp[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_rx_boundary();
      txq.delete();
      // Each byte arrives in the very cycle the inter-byte timer expires.
      send_byte(8'h52);
      repeat (RXT) tick();
      send_byte(8'h00);
      repeat (RXT) tick();
      send_byte(8'h08);
      total_cnt++; if (bus_req !== 1'b1) $display("FAIL edge_req: got %b required 1", bus_req); else pass_cnt++;
      total_cnt++; if (bus_addr !== 16'h0008) $display("FAIL edge_addr: got %h required 0008", bus_addr); else pass_cnt++;
      bus_rdat = 32'h0;
      bus_ack  = 1'b1;
      tick();
      bus_ack  = 1'b0;
      wait_tx(4, 100);
      total_cnt++; if (txq.size() != 4) $display("FAIL edge_tx_count: got %0d required 4", txq.size()); else pass_cnt++;
   endtask

   task automatic test_bus_timeout();
      txq.delete();
      breq_cycles = 0;
      send_byte(8'h52);
      send_byte(8'h00);
      send_byte(8'h30);
      total_cnt++; if (bus_req !== 1'b1) $display("FAIL bto_req_rise: got %b required 1", bus_req); else pass_cnt++;
      send_byte(8'h41);
      send_byte(8'h57);
      for (int i = 0; i < int'(BT) + 20; i++) begin
         if (bus_req !== 1'b1) break;
         tick();
      end
      total_cnt++; if (bus_req !== 1'b0) $display("FAIL bto_req_drop: got %b required 0", bus_req); else pass_cnt++;
      total_cnt++; if (breq_cycles != int'(BT)) $display("FAIL bto_req_len: got %0d cycles required %0d", breq_cycles, BT); else pass_cnt++;
      wait_tx(1, 50);
      repeat (5) tick();
      total_cnt++; if (txq.size() != 1) $display("FAIL bto_tx_count: got %0d required 1", txq.size()); else pass_cnt++;
      total_cnt++;
      if (txq.size() < 1 || txq[0] !== 8'h45) $display("FAIL bto_tx_byte: got %h required 45", (txq.size() > 0) ? txq[0] : 8'hxx);
      else pass_cnt++;
      total_cnt++; if (breq_cycles != int'(BT)) $display("FAIL bto_no_extra_req: got %0d cycles required %0d", breq_cycles, BT); else pass_cnt++;
   endtask

   task automatic test_reset_mid_response();
      txq.delete();
      send_byte(8'h52);
      send_byte(8'h00);
      send_byte(8'h40);
      bus_rdat = 32'hCAFEF00D;
      bus_ack  = 1'b1;
      tick();
      bus_ack  = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (txq.size() >= 1) break;
         tick();
      end
      rst = 1'b1;
      tick();
      total_cnt++; if (txd !== 8'h00) $display("FAIL mid_txd: got %h required 00", txd); else pass_cnt++;
      total_cnt++; if (txv !== 1'b0) $display("FAIL mid_txv: got %b required 0", txv); else pass_cnt++;
      total_cnt++; if (bus_req !== 1'b0) $display("FAIL mid_req: got %b required 0", bus_req); else pass_cnt++;
      total_cnt++; if (bus_addr !== 16'h0000) $display("FAIL mid_addr: got %h required 0000", bus_addr); else pass_cnt++;
      total_cnt++; if (bus_wdat !== 32'h0) $display("FAIL mid_wdat: got %h required 00000000", bus_wdat); else pass_cnt++;
      rst = 1'b0;
      repeat (20) tick();
      total_cnt++; if (txq.size() != 1) $display("FAIL mid_tx_count: got %0d required 1", txq.size()); else pass_cnt++;
      total_cnt++;
      if (txq.size() < 1 || txq[0] !== 8'hCA) $display("FAIL mid_tx_byte: got %h required ca", (txq.size() > 0) ? txq[0] : 8'hxx);
      else pass_cnt++;
   endtask

   task automatic test_after_reset();
      logic [7:0] fr [0:6];
      fr = '{8'h57, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h01};
      txq.delete();
      for (int i = 0; i < 7; i++) send_byte(fr[i]);
      total_cnt++; if (bus_req !== 1'b1) $display("FAIL ar_req: got %b required 1", bus_req); else pass_cnt++;
      total_cnt++; if (bus_addr !== 16'h1234) $display("FAIL ar_addr: got %h required 1234", bus_addr); else pass_cnt++;
      total_cnt++; if (bus_wdat !== 32'h00000001) $display("FAIL ar_wdat: got %h required 00000001", bus_wdat); else pass_cnt++;
      bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0;
      wait_tx(1, 50);
      total_cnt++;
      if (txq.size() != 1 || txq[0] !== 8'h4B) $display("FAIL ar_tx: got %0d bytes first %h required 1 byte 4b", txq.size(), (txq.size() > 0) ? txq[0] : 8'hxx);
      else pass_cnt++;
   endtask

   initial begin
      rst      = 1'b1;
      rxd      = 8'h00;
      rxv      = 1'b0;
      cts      = 1'b1;
      bus_rdat = 32'h0;
      bus_ack  = 1'b0;
      test_reset();
      test_write();
      test_read();
      test_unknown();
      test_rx_timeout();
      test_rx_boundary();
      test_bus_timeout();
      test_reset_mid_response();
      test_after_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/uart_dbg_bridge.md
# uart_dbg_bridge

Debug register-access bridge at the host-facing end of the `uart` byte interface. It consumes received bytes (`rxd`/`rxv`), parses host command frames and performs single-word register reads and writes on a simple request/acknowledge bus. It returns response bytes through `txd`/`txv`, paced by `cts`. It sits between `uart` and the debug register file, giving a PC terminal peek/poke access to the design.

## Interface
- `ADDR_BYTES`, 2: address bytes per frame; bus address width = 8*ADDR_BYTES.
- `DATA_BYTES`, 4: data bytes per word; bus data width = 8*DATA_BYTES.
- `RX_TIMEOUT`, 1250000: maximum clk cycles between frame bytes (10 ms at 125 MHz).
- `BUS_TIMEOUT`, 255: maximum clk cycles from `bus_req` rise to `bus_ack`.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous reset, active-high.
- `rxd`  in  8  received byte from `uart`.
- `rxv`  in  1  one-cycle strobe; `rxd` is valid.
- `txd`  out  8  byte to transmit.
- `txv`  out  1  one-cycle transmit strobe.
- `cts`  in  1  transmitter ready for a byte.
- `bus_req`  out  1  access request; held until ack or timeout.
- `bus_we`  out  1  1 = write, 0 = read; stable while `bus_req`.
- `bus_addr`  out  8*ADDR_BYTES  word address; stable while `bus_req`.
- `bus_wdat`  out  8*DATA_BYTES  write data; stable while `bus_req`.
- `bus_rdat`  in  8*DATA_BYTES  read data; valid in the `bus_ack` cycle.
- `bus_ack`  in  1  one-cycle completion strobe.

## Operation
- Frames are MSB-first throughout.
  - Write: `0x57` ('W'), then ADDR_BYTES address bytes, then DATA_BYTES data bytes.
  - Read: `0x52` ('R'), then ADDR_BYTES address bytes.
- Responses:
  - Write complete: `0x4B` ('K').
  - Read complete: DATA_BYTES bytes of `bus_rdat`, MSB first.
  - Unknown command byte or bus timeout: `0x45` ('E').
- FSM states:
  - IDLE → CMD decode on `rxv`. 'W' or 'R' → ADDR. Any other byte → RESP with 'E'.
  - ADDR: shift in address bytes. After the last one, 'R' → BUS and 'W' → DATA.
  - DATA: shift in data bytes. After the last one → BUS.
  - BUS: `bus_req`=1 until `bus_ack` or timeout → RESP.
  - RESP: serialize the response bytes → IDLE.
- Byte counter counts 0..ADDR_BYTES-1 or 0..DATA_BYTES-1; it clears on each state entry.
- Inter-byte timer runs in ADDR and DATA. It reloads on every `rxv`. On expiry, return to IDLE silently with no bus access and no response.
- `rxv` in BUS or RESP: the byte is dropped and does not start a new frame.
- Address and data registers hold their last values after the frame; they are not cleared in IDLE.

## Timing
- Reset values: `txd`=0, `txv`=0, `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_wdat`=0, FSM=IDLE, all counters 0.
- Reset mid-frame or mid-response aborts immediately. Remaining response bytes are never sent.
- `bus_req` rises the cycle after the last frame byte's `rxv`. It falls the cycle after `bus_ack`.
- `bus_ack` arriving in the same cycle the bus timer reaches BUS_TIMEOUT counts as success.
- `bus_rdat` is captured in the `bus_ack` cycle.
- `txv` is asserted only in a cycle where `cts`=1, for exactly one cycle.
  - After each `txv`, `cts` is ignored for the next cycle; `cts` from `uart_tx` is registered.
  - Minimum byte spacing is therefore 2 cycles.
- The first response `txv` comes no earlier than 1 cycle after entering RESP.
- IDLE is re-entered the cycle after the last response `txv`. A `rxv` in that cycle is accepted as a command byte.
- `rxv` in the same cycle as RX timeout expiry: the byte is accepted and the timer reloads.

## Structure
- Shared package `uart_dbg_pkg` holds:
  - command/response constants `CMD_WR`=8'h57, `CMD_RD`=8'h52, `RSP_OK`=8'h4B, `RSP_ERR`=8'h45;
  - the FSM state enum.
- One sub-module, `uart_dbg_ser`: a response serializer. It loads a DATA_BYTES-wide word plus a length, emits bytes MSB first under the `cts`/`txv` rule, and raises `done` for one cycle.

## Test plan
- Write: rx 57 00 10 DE AD BE EF; `bus_ack` 3 cycles after `bus_req` → `bus_we`=1, `bus_addr`=16'h0010, `bus_wdat`=32'hDEADBEEF; tx 4B.
- Read: rx 52 00 20, `bus_rdat`=32'h12345678; `cts` toggled randomly → tx 12 34 56 78 in order; no `txv` while `cts`=0; no two `txv` in adjacent cycles.
- Unknown command: rx 41 → tx 45; no `bus_req`. A following 52 00 20 completes normally.
- RX timeout: rx 57 00, then silence for RX_TIMEOUT+1 cycles → no `bus_req`, no tx. A subsequent 52 00 04 reads address 0x0004.
- Bus timeout: read with `bus_ack` never asserted → `bus_req` high for BUS_TIMEOUT cycles then low; tx 45. Bytes sent during BUS are ignored.
- Reset mid-response: assert `rst` after the first of 4 read bytes → all outputs at reset values next cycle; no further `txv`.
